// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential imem fetch into a DEPTH-entry queue, with redirect flush and LAA word routing
module fetch_prefetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [6:0] CUST_OPC = 7'b0001011
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       prog,
  input  logic [XLEN-1:0]            prog_addr,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_addr,
  input  logic                       stall,
  input  logic                       laa_busy,
  output logic                       imem_en,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_dout,
  output logic                       ins_valid,
  output logic [XLEN-1:0]            ins,
  output logic [XLEN-1:0]            ins_pc,
  output logic                       laa_valid,
  output logic [XLEN-1:0]            laa_ins,
  output logic [$clog2(DEPTH):0]     q_count
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] pc, req_pc;
  logic inflight;
  logic [XLEN-1:0] q_ins [DEPTH];
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic issue, show, is_cust, push, pop;
  // inflight counts against capacity so a returning word always has a slot
  assign issue = !Rst && !prog && !redirect && ((cnt + (AW+1)'(inflight)) < (AW+1)'(DEPTH));
  assign show = (cnt != '0) && !prog && !Rst;
  assign is_cust = q_ins[rd][6:0] == CUST_OPC;
  assign ins_valid = show && !is_cust;
  assign laa_valid = show && is_cust;
  assign ins = ins_valid ? q_ins[rd] : '0;
  assign ins_pc = ins_valid ? q_pc[rd] : '0;
  assign laa_ins = laa_valid ? q_ins[rd] : '0;
  assign q_count = cnt;
  assign imem_en = !Rst && (prog || issue);
  assign imem_addr = prog ? prog_addr : pc;
  assign push = inflight && !redirect && !prog;
  assign pop = !redirect && !stall && (ins_valid || (laa_valid && !laa_busy));
  always_ff @(posedge clk) begin
    if (Rst) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      cnt <= '0;
      rd <= '0;
      wr <= '0;
    end else if (prog || redirect) begin
      pc <= prog ? RESET_PC : {redirect_addr[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      cnt <= '0;
      rd <= '0;
      wr <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc <= pc + XLEN'(4);
        req_pc <= pc;
      end
      if (push) begin
        q_ins[wr] <= imem_dout;
        q_pc[wr] <= req_pc;
        wr <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed and random stimulus checked against a queue-based reference model
module tb_fetch_prefetch_queue;
  logic clk = 0, Rst, prog, redirect, stall, laa_busy;
  logic [31:0] prog_addr, redirect_addr, imem_addr, imem_dout, ins, ins_pc, laa_ins;
  logic imem_en, ins_valid, laa_valid;
  logic [2:0] q_count;
  int checks = 0, failures = 0;
  logic [31:0] cust_addr = 32'hFFFF_FFFF;
  bit rnd_cust = 0;
  logic [31:0] mq[$], mp[$];
  logic [31:0] mpc = 0, minf_pc = 0;
  int minf = 0;

  fetch_prefetch_queue dut (
    .clk(clk), .Rst(Rst), .prog(prog), .prog_addr(prog_addr), .redirect(redirect),
    .redirect_addr(redirect_addr), .stall(stall), .laa_busy(laa_busy), .imem_en(imem_en),
    .imem_addr(imem_addr), .imem_dout(imem_dout), .ins_valid(ins_valid), .ins(ins),
    .ins_pc(ins_pc), .laa_valid(laa_valid), .laa_ins(laa_ins), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a == cust_addr || (rnd_cust && a[4:2] == 3'd5)) ? {a[24:0], 7'b0001011} : a;
  endfunction

  always @(posedge clk) if (imem_en) imem_dout <= word_of(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic p, input logic [31:0] pa, input logic rdr,
                     input logic [31:0] ra, input logic st, input logic bz);
    logic show, cust, ev, lv, pop;
    logic [31:0] hd;
    int n;
    Rst = r; prog = p; prog_addr = pa; redirect = rdr; redirect_addr = ra; stall = st; laa_busy = bz;
    #1;
    n = mq.size();
    show = n != 0 && !p && !r;
    hd = show ? mq[0] : 32'h0;
    cust = hd[6:0] == 7'b0001011;
    ev = show && !cust;
    lv = show && cust;
    check("imem_en", {31'b0, imem_en}, {31'b0, !r && (p || (!rdr && n + minf < 4))});
    if (!r) begin
      check("imem_addr", imem_addr, p ? pa : mpc);
      check("ins_valid", {31'b0, ins_valid}, {31'b0, ev});
      check("ins", ins, ev ? hd : 32'h0);
      check("ins_pc", ins_pc, ev ? mp[0] : 32'h0);
      check("laa_valid", {31'b0, laa_valid}, {31'b0, lv});
      check("laa_ins", laa_ins, lv ? hd : 32'h0);
      check("q_count", {29'b0, q_count}, n);
    end
    @(posedge clk);
    if (r) begin
      mpc = 0; minf = 0; mq.delete(); mp.delete();
    end else if (p || rdr) begin
      mpc = p ? 32'h0 : {ra[31:2], 2'b00}; minf = 0; mq.delete(); mp.delete();
    end else begin
      pop = !st && (ev || (lv && !bz));
      if (pop) begin void'(mq.pop_front()); void'(mp.pop_front()); end
      if (minf != 0) begin mq.push_back(word_of(minf_pc)); mp.push_back(minf_pc); end
      if (n + minf < 4) begin minf_pc = mpc; mpc = mpc + 4; minf = 1; end
      else minf = 0;
    end
    #1;
  endtask

  task automatic run(input int k, input logic st, input logic bz);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, st, bz);
  endtask

  initial begin
    int k;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // free run: first word appears two cycles after the first issue
    run(2, 0, 0);
    check("first_valid", {31'b0, ins_valid}, 32'h1);
    check("first_pc", ins_pc, 32'h0);
    run(6, 0, 0);
    run(10, 1, 0);
    check("sat_count", {29'b0, q_count}, 32'h4);
    check("sat_en", {31'b0, imem_en}, 32'h0);
    run(8, 0, 0);
    run(6, 1, 0);
    cyc(0, 0, 0, 1, 32'h103, 1, 0);
    k = 0;
    while (!ins_valid && k < 8) begin cyc(0, 0, 0, 0, 0, 0, 0); k++; end
    check("redir_lat", k, 2);
    check("redir_pc", ins_pc, 32'h100);
    run(4, 0, 0);
    // custom word at 0x8 held while the accelerator is busy
    cust_addr = 32'h8;
    cyc(0, 0, 0, 1, 32'h0, 0, 1);
    k = 0;
    while (!laa_valid && k < 10) begin cyc(0, 0, 0, 0, 0, 0, 1); k++; end
    check("laa_seen", {31'b0, laa_valid}, 32'h1);
    check("laa_ins_dir", laa_ins, 32'h40B);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("laa_hold", {31'b0, laa_valid}, 32'h1);
      check("laa_no_ins", {31'b0, ins_valid}, 32'h0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("after_laa_valid", {31'b0, ins_valid}, 32'h1);
    check("after_laa_pc", ins_pc, 32'hC);
    cust_addr = 32'hFFFF_FFFF;
    run(3, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h14, 0, 0, 0, 0);
    check("prog_addr", imem_addr, 32'h14);
    check("prog_en", {31'b0, imem_en}, 32'h1);
    check("prog_inv", {31'b0, ins_valid | laa_valid}, 32'h0);
    prog = 0; #1;
    check("prog_fall_addr", imem_addr, 32'h0);
    check("prog_fall_en", {31'b0, imem_en}, 32'h1);
    run(5, 0, 0);
    cyc(1, 0, 0, 1, 32'h200, 0, 0);
    Rst = 0; redirect = 0; #1;
    check("rst_pc", imem_addr, 32'h0);
    check("rst_cnt", {29'b0, q_count}, 32'h0);
    run(3, 0, 0);
    cyc(0, 0, 0, 1, 32'hFFFF_FFF6, 0, 0);
    run(6, 0, 0);
    rnd_cust = 1;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3, $urandom,
          $urandom_range(0, 99) < 8, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom_range(0, 4095),
          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 40);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
